// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the default datapath width.
package mdu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One-bit-per-enable magnitude engine: shift-add multiply or restoring divide
// on a shared {acc, shift} register pair with a single adder/subtractor.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] b_q;
  logic             div_q;

  logic [WIDTH:0]   op_a;
  logic [WIDTH+1:0] op_b;
  logic             cin;
  logic [WIDTH+1:0] sum;

  // Divide computes trial = {acc, next dividend bit} - divisor; the extra top
  // bit of sum is the borrow that decides whether the trial is kept.
  always_comb begin
    if (div_q) begin
      op_a = {acc_q, sh_q[WIDTH-1]};
      op_b = ~{2'b00, b_q};
      cin  = 1'b1;
    end else begin
      op_a = {1'b0, acc_q};
      op_b = sh_q[0] ? {2'b00, b_q} : '0;
      cin  = 1'b0;
    end
    sum = {1'b0, op_a} + op_b + {{(WIDTH+1){1'b0}}, cin};
  end

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      acc_q <= '0;
      sh_q  <= a_i;
      b_q   <= b_i;
      div_q <= is_div_i;
    end else if (en_i) begin
      if (div_q) begin
        if (sum[WIDTH+1]) begin
          acc_q <= op_a[WIDTH-1:0];
          sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_q <= sum[WIDTH-1:0];
          sh_q  <= {sh_q[WIDTH-2:0], 1'b1};
        end
      end else begin
        acc_q <= sum[WIDTH:1];
        sh_q  <= {sum[0], sh_q[WIDTH-1:1]};
      end
    end
  end

  assign hi_o = acc_q;
  assign lo_o = sh_q;

endmodule

// File: rtl/mdu_hilo_unit.sv
// Multiply/divide unit with HI/LO registers, Start/Busy/Done handshake and
// MTHI/MTLO paths. Define MDU_FAST_MULT_EN for single-cycle MULT/MULTU.
module mdu_hilo_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  op_e              op_q;
  logic             sa_q;
  logic             sb_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  op_e              op_in;
  logic             sa_in;
  logic             sb_in;
  logic             launch;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [2*WIDTH-1:0] prod;

  assign op_in  = op_e'(Op);
  assign sa_in  = op_is_signed(op_in) & OperandA[WIDTH-1];
  assign sb_in  = op_is_signed(op_in) & OperandB[WIDTH-1];
  assign launch = (state_q == S_IDLE) && Start;

  mdu_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk_i    (Clock),
    .load_i   (launch),
    .en_i     (state_q == S_CALC),
    .is_div_i (op_is_div(op_in)),
    .a_i      (neg_if(sa_in, OperandA)),
    .b_i      (neg_if(sb_in, OperandB)),
    .hi_o     (core_hi),
    .lo_o     (core_lo)
  );

  // Sign fixup applied to the magnitude result during FIX.
  always_comb begin
    prod = {core_hi, core_lo};
`ifdef MDU_FAST_MULT_EN
    if (!op_is_div(op_q)) begin
      prod = (2*WIDTH)'(neg_if(sa_q, a_q)) * (2*WIDTH)'(neg_if(sb_q, b_q));
    end
`endif
    if (sa_q ^ sb_q) begin
      prod = -prod;
    end
    hi_d = prod[2*WIDTH-1:WIDTH];
    lo_d = prod[WIDTH-1:0];
    if (op_is_div(op_q)) begin
      if (b_q == '0) begin
        hi_d = a_q;
        lo_d = '1;
      end else begin
        hi_d = neg_if(sa_q, core_hi);
        lo_d = neg_if(sa_q ^ sb_q, core_lo);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (HiWrite) hi_q <= WriteData;
          if (LoWrite) lo_q <= WriteData;
          if (Start) begin
            op_q   <= op_in;
            sa_q   <= sa_in;
            sb_q   <= sb_in;
            a_q    <= OperandA;
            b_q    <= OperandB;
            cnt_q  <= '0;
            busy_q <= 1'b1;
`ifdef MDU_FAST_MULT_EN
            state_q <= op_is_div(op_in) ? S_CALC : S_FIX;
`else
            state_q <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Bench for mdu_hilo_unit: directed vectors plus randomized traffic checked
// every cycle against an arithmetic reference model.
module tb_mdu_hilo_unit;

`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic        Clock = 1'b0;
  logic        Clear, Start, HiWrite, LoWrite;
  logic [1:0]  Op;
  logic [31:0] OperandA, OperandB, WriteData;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  always #5 Clock = ~Clock;

  mdu_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .Clock(Clock), .Clear(Clear), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural result {Hi, Lo} from plain arithmetic.
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int sa, sb;
    case (op)
      2'd0: begin
        p = longint'(signed'(a)) * longint'(signed'(b));
        return p;
      end
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Reference model: transaction level, updated on every rising edge.
  bit          mvalid = 0;
  bit          exp_busy = 0, exp_done = 0;
  logic [31:0] exp_hi = 0, exp_lo = 0, pend_hi = 0, pend_lo = 0;
  int          remaining = 0;

  always @(posedge Clock) begin
    logic [63:0] r;
    exp_done = 0;
    if (Clear) begin
      mvalid = 1;
      exp_busy = 0;
      exp_hi = 0;
      exp_lo = 0;
      remaining = 0;
    end else if (remaining > 0) begin
      remaining--;
      if (remaining == 0) begin
        exp_busy = 0;
        exp_done = 1;
        exp_hi = pend_hi;
        exp_lo = pend_lo;
      end
    end else begin
      if (HiWrite) exp_hi = WriteData;
      if (LoWrite) exp_lo = WriteData;
      if (Start) begin
        r = ref_op(Op, OperandA, OperandB);
        pend_hi = r[63:32];
        pend_lo = r[31:0];
        remaining = (Op[1] ? DIV_LAT : MUL_LAT) - 1;
        exp_busy = 1;
      end
    end
  end

  always @(negedge Clock) begin
    if (mvalid) begin
      n_cmp++;
      if ({Busy, Done, Hi, Lo} !== {exp_busy, exp_done, exp_hi, exp_lo}) begin
        n_fail++;
        $display("FAIL cycle t=%0t: busy=%b done=%b hi=%h lo=%h, expected busy=%b done=%b hi=%h lo=%h",
                 $time, Busy, Done, Hi, Lo, exp_busy, exp_done, exp_hi, exp_lo);
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom % 7)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom % 8);
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called right after a falling edge; returns at the falling edge of the Done cycle.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    int  cyc_n, busy_n;
    bit  seen;
    Start = 1; Op = op; OperandA = a; OperandB = b;
    cyc_n = 0; busy_n = 0; seen = 0;
    while (!seen && cyc_n < 100) begin
      @(negedge Clock);
      Start = 0;
      cyc_n++;
      if (Busy) busy_n++;
      if (Done) seen = 1;
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    chk({name, "_latency"}, 64'(cyc_n), 64'(lat));
    chk({name, "_busy_cycles"}, 64'(busy_n), 64'(lat - 1));
    chk({name, "_hi"}, 64'(Hi), 64'(eh));
    chk({name, "_lo"}, 64'(Lo), 64'(el));
  endtask

  initial begin
    int  n;
    bit  seen;
    Clear = 1; Start = 0; Op = 0; OperandA = 0; OperandB = 0;
    HiWrite = 0; LoWrite = 0; WriteData = 0;
    repeat (2) @(negedge Clock);
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_done", 64'(Done), 64'd0);
    chk("reset_hi", 64'(Hi), 64'd0);
    chk("reset_lo", 64'(Lo), 64'd0);
    Clear = 0;

    chk("pin_mult", ref_op(2'd0, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
    chk("pin_multu", ref_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    chk("pin_divu", ref_op(2'd3, 32'd100, 32'd7), {32'd2, 32'd14});
    chk("pin_div_neg", ref_op(2'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("pin_div0", ref_op(2'd2, 32'h1234_5678, 32'd0), 64'h1234_5678_FFFF_FFFF);
    chk("pin_div_ovf", ref_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

    @(negedge Clock);
    run_op("mult_m3x5", 2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
    run_op("divu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);
    run_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    run_op("div_by0", 2'd2, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, DIV_LAT);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV_LAT);
    run_op("mult_6x7", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42, MUL_LAT);

    // Clear in the middle of a divide.
    Start = 1; Op = 2'd3; OperandA = 32'd100; OperandB = 32'd7;
    @(negedge Clock);
    Start = 0;
    repeat (9) @(negedge Clock);
    Clear = 1;
    @(negedge Clock);
    Clear = 0;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_done", 64'(Done), 64'd0);
    chk("abort_hi", 64'(Hi), 64'd0);
    chk("abort_lo", 64'(Lo), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge Clock);
      if (Done) seen = 1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    // Start/HiWrite/LoWrite and operand changes during Busy are ignored.
    Start = 1; Op = 2'd3; OperandA = 32'd1000; OperandB = 32'd3;
    @(negedge Clock);
    Start = 0;
    repeat (2) @(negedge Clock);
    Start = 1; Op = 2'd0; OperandA = 32'd5; OperandB = 32'd9;
    HiWrite = 1; LoWrite = 1; WriteData = 32'hDEAD_BEEF;
    @(negedge Clock);
    Start = 0; HiWrite = 0; LoWrite = 0; OperandA = 32'd77; OperandB = 32'd1;
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      @(negedge Clock);
      n++;
      if (Done) seen = 1;
    end
    chk("busy_ign_done_seen", 64'(seen), 64'd1);
    chk("busy_ign_hi", 64'(Hi), 64'd1);
    chk("busy_ign_lo", 64'(Lo), 64'd333);

    // MTHI / MTLO in IDLE.
    HiWrite = 1; WriteData = 32'hA5A5_A5A5;
    @(negedge Clock);
    HiWrite = 0;
    chk("mthi", 64'(Hi), 64'hA5A5_A5A5);
    chk("mthi_lo_kept", 64'(Lo), 64'd333);
    HiWrite = 1; LoWrite = 1; WriteData = 32'h5A5A_0F0F;
    @(negedge Clock);
    HiWrite = 0; LoWrite = 0;
    chk("mthilo_hi", 64'(Hi), 64'h5A5A_0F0F);
    chk("mthilo_lo", 64'(Lo), 64'h5A5A_0F0F);

    // Randomized traffic, checked cycle by cycle against the model.
    repeat (3000) begin
      Clear     = ($urandom % 500) == 0;
      Start     = ($urandom % 3) == 0;
      Op        = 2'($urandom);
      OperandA  = pick();
      OperandB  = pick();
      HiWrite   = ($urandom % 6) == 0;
      LoWrite   = ($urandom % 6) == 0;
      WriteData = $urandom;
      @(negedge Clock);
    end
    Clear = 0; Start = 0; HiWrite = 0; LoWrite = 0;
    repeat (40) @(negedge Clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
